// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch unit and its BTB.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic ctr_e ctr_step(ctr_e c, logic taken);
    ctr_e r;
    r = c;
    unique case (c)
      SNT: r = taken ? WNT : SNT;
      WNT: r = taken ? WT  : SNT;
      WT:  r = taken ? ST  : WNT;
      ST:  r = taken ? ST  : WT;
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-unit bus: hazard/EX controls, BTB training, imem and IF/ID outputs.
// Perf-counter outputs exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_if;
  import fetch_pkg::*;

  logic            stall_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [XLEN-1:0] upd_target_i;
  logic [XLEN-1:0] imem_addr_o;
  logic [XLEN-1:0] imem_rdata_i;
  logic [XLEN-1:0] instruction_o;
  logic [XLEN-1:0] pc_o;
  logic            br_pred_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     pred_taken_cnt_o;
  logic [31:0]     redirect_cnt_o;
`endif

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
           upd_target_i, imem_rdata_i,
`ifdef FETCH_PERF_CNT_EN
    output pred_taken_cnt_o, redirect_cnt_o,
`endif
    output imem_addr_o, instruction_o, pc_o, br_pred_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
           upd_target_i, imem_rdata_i,
`ifdef FETCH_PERF_CNT_EN
    input  pred_taken_cnt_o, redirect_cnt_o,
`endif
    input  imem_addr_o, instruction_o, pc_o, br_pred_o
  );

endinterface

// File: rtl/fetch_btb.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational lookup,
// synchronous update from EX.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int unsigned BTB_IDX_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int unsigned Entries = 2 ** BTB_IDX_W;
  localparam int unsigned TagW    = 30 - BTB_IDX_W;

  logic            valid_q  [Entries];
  logic [TagW-1:0] tag_q    [Entries];
  logic [XLEN-1:0] target_q [Entries];
  ctr_e            ctr_q    [Entries];

  logic [BTB_IDX_W-1:0] lidx, uidx;
  logic [TagW-1:0]      ltag, utag;
  logic                 lhit, uhit;

  assign lidx = lookup_pc[BTB_IDX_W+1:2];
  assign ltag = lookup_pc[XLEN-1:BTB_IDX_W+2];
  assign uidx = upd_pc[BTB_IDX_W+1:2];
  assign utag = upd_pc[XLEN-1:BTB_IDX_W+2];

  assign lhit        = valid_q[lidx] && (tag_q[lidx] == ltag);
  assign uhit        = valid_q[uidx] && (tag_q[uidx] == utag);
  assign pred_taken  = lhit && ctr_q[lidx][1];
  assign pred_target = target_q[lidx];

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        valid_q[uidx] <= 1'b1;
        // A taken branch that misses (re)allocates the entry as weakly taken.
        ctr_q[uidx]   <= uhit ? ctr_step(ctr_q[uidx], 1'b1) : WT;
      end else if (uhit) begin
        ctr_q[uidx]   <= ctr_step(ctr_q[uidx], 1'b0);
      end
    end
  end

  // Tag/target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      tag_q[uidx]    <= utag;
      target_q[uidx] <= {upd_target[XLEN-1:2], 2'b00};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF-stage front end: PC register, next-PC selection and BTB prediction.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     BTB_IDX_W = 4
) (
  input logic    clk,
  input logic    reset_n,
  fetch_if.master bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [XLEN-1:0] pred_next;

  fetch_btb #(
    .BTB_IDX_W (BTB_IDX_W)
  ) u_btb (
    .clk         (clk),
    .reset_n     (reset_n),
    .lookup_pc   (pc_q),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (bus.upd_valid_i),
    .upd_pc      (bus.upd_pc_i),
    .upd_taken   (bus.upd_taken_i),
    .upd_target  (bus.upd_target_i)
  );

  assign pred_next = pred_taken ? pred_target : pc_q + 32'd4;

  always_comb begin
    pc_d = pred_next;
    if (bus.redirect_i) begin
      pc_d = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (bus.stall_i) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.imem_addr_o   = pc_q;
  assign bus.instruction_o = bus.imem_rdata_i;
  assign bus.br_pred_o     = pred_taken;

  logic unused_bits;
  assign unused_bits = ^bus.redirect_pc_i[1:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pred_taken_cnt_q, redirect_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pred_taken_cnt_q <= '0;
      redirect_cnt_q   <= '0;
    end else begin
      if (pred_taken && !bus.stall_i && !bus.redirect_i) begin
        pred_taken_cnt_q <= pred_taken_cnt_q + 32'd1;
      end
      if (bus.redirect_i) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign bus.pred_taken_cnt_o = pred_taken_cnt_q;
  assign bus.redirect_cnt_o   = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table plus reset corner sequence.
module tb_fetch_unit;

  logic clk;
  logic reset_n;

  fetch_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BTB_IDX_W (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_model(logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  assign bus.imem_rdata_i = imem_model(bus.imem_addr_o);

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] exp_pc;
    logic        exp_pred;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
  } exp_t;

  vec_t vecs[32];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic s, logic r, logic [31:0] rp, logic uv, logic [31:0] up,
                              logic ut, logic [31:0] utg, logic [31:0] epc, logic ep);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp; v.uv = uv; v.upc = up; v.ut = ut; v.utgt = utg;
    v.exp_pc = epc; v.exp_pred = ep;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check_outputs(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".pc"}, bus.pc_o, e.pc);
    check({tag, ".addr"}, bus.imem_addr_o, e.pc);
    check({tag, ".pred"}, {31'd0, bus.br_pred_o}, {31'd0, e.pred});
    check({tag, ".instr"}, bus.instruction_o, imem_model(e.pc));
  endtask

  task automatic drive_idle();
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.upd_valid_i   = 1'b0;
    bus.upd_pc_i      = '0;
    bus.upd_taken_i   = 1'b0;
    bus.upd_target_i  = '0;
  endtask

  task automatic run_vec(vec_t v, string tag);
    exp_t e;
    bus.stall_i       = v.stall;
    bus.redirect_i    = v.redir;
    bus.redirect_pc_i = v.rpc;
    bus.upd_valid_i   = v.uv;
    bus.upd_pc_i      = v.upc;
    bus.upd_taken_i   = v.ut;
    bus.upd_target_i  = v.utgt;
    e.pc   = v.exp_pc;
    e.pred = v.exp_pred;
    sb.push_back(e);
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               stall redir rpc           uv upc       ut utgt      exp_pc        pred
    vecs[0]  = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0000, 0);
    vecs[1]  = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0004, 0);
    vecs[2]  = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0008, 0);
    vecs[3]  = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_000C, 0);
    vecs[4]  = mk(1, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0010, 0);
    vecs[5]  = mk(1, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0010, 0);
    vecs[6]  = mk(1, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0010, 0);
    vecs[7]  = mk(1, 1, 32'h203,       0, 32'h0,   0, 32'h0,   32'h0000_0010, 0);
    vecs[8]  = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0200, 0);
    vecs[9]  = mk(0, 1, 32'h3C,        0, 32'h0,   0, 32'h0,   32'h0000_0204, 0);
    vecs[10] = mk(0, 0, 32'h0,         1, 32'h40,  1, 32'h100, 32'h0000_003C, 0);
    vecs[11] = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0040, 1);
    vecs[12] = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0100, 0);
    vecs[13] = mk(0, 0, 32'h0,         1, 32'h40,  1, 32'h100, 32'h0000_0104, 0);
    vecs[14] = mk(0, 0, 32'h0,         1, 32'h40,  1, 32'h100, 32'h0000_0108, 0);
    vecs[15] = mk(0, 1, 32'h40,        1, 32'h40,  0, 32'h100, 32'h0000_010C, 0);
    vecs[16] = mk(0, 0, 32'h0,         1, 32'h40,  0, 32'h100, 32'h0000_0040, 1);
    vecs[17] = mk(0, 1, 32'h40,        0, 32'h0,   0, 32'h0,   32'h0000_0100, 0);
    vecs[18] = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0040, 0);
    vecs[19] = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0044, 0);
    vecs[20] = mk(0, 0, 32'h0,         1, 32'h40,  1, 32'h100, 32'h0000_0048, 0);
    vecs[21] = mk(0, 1, 32'h440,       1, 32'h440, 0, 32'h0,   32'h0000_004C, 0);
    vecs[22] = mk(0, 1, 32'h40,        0, 32'h0,   0, 32'h0,   32'h0000_0440, 0);
    vecs[23] = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0040, 1);
    vecs[24] = mk(0, 1, 32'hFFFF_FFFF, 0, 32'h0,   0, 32'h0,   32'h0000_0100, 0);
    vecs[25] = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'hFFFF_FFFC, 0);
    vecs[26] = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0000, 0);
    vecs[27] = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0004, 0);
    vecs[28] = mk(1, 0, 32'h0,         1, 32'h8,   1, 32'h300, 32'h0000_0008, 0);
    vecs[29] = mk(1, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0008, 1);
    vecs[30] = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0008, 1);
    vecs[31] = mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,   32'h0000_0300, 0);

    reset_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset.pc", bus.pc_o, 32'h0);
    check("reset.pred", {31'd0, bus.br_pred_o}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset mid-operation must beat a pending redirect and BTB update.
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h500;
    bus.upd_valid_i   = 1'b1;
    bus.upd_pc_i      = 32'h300;
    bus.upd_taken_i   = 1'b1;
    bus.upd_target_i  = 32'h700;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive_idle();
    run_vec(mk(0, 1, 32'h40,  0, 32'h0, 0, 32'h0, 32'h0000_0000, 0), "rst2.a");
    run_vec(mk(0, 1, 32'h300, 0, 32'h0, 0, 32'h0, 32'h0000_0040, 0), "rst2.b");
    run_vec(mk(0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h0000_0300, 0), "rst2.c");
    run_vec(mk(0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h0000_0304, 0), "rst2.d");

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard.drain: got %0d left want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
